smooth_stream: RTL and testbench
================================

SMOOTH_STREAM -- requirements
Module: smooth_stream

Interface
REQ-001 SHALL have parameter PIX_W, default 12, pixel bit width.
REQ-002 SHALL have parameter IMG_W, default 64, pixels per line, legal range 3..1024.
REQ-003 SHALL have parameter IMG_H, default 64, lines per frame, legal range 3..1024.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port s_valid  input  1  input pixel valid.
REQ-007 SHALL have port s_ready  output  1  input pixel accepted when s_valid && s_ready.
REQ-008 SHALL have port s_sof  input  1  marks first pixel (row 0, col 0) of a frame.
REQ-009 SHALL have port s_data  input  PIX_W  raster-order input pixel.
REQ-010 SHALL have port mode  input  1  0 = 3x3 box average, 1 = 3x3 Gaussian 1-2-1.
REQ-011 SHALL have port m_valid  output  1  output pixel valid.
REQ-012 SHALL have port m_ready  input  1  downstream accepts when m_valid && m_ready.
REQ-013 SHALL have port m_data  output  PIX_W  smoothed pixel.
REQ-014 SHALL have port m_sof  output  1  first output pixel of frame.
REQ-015 SHALL have port m_eol  output  1  last output pixel of a line.

Function
REQ-016 SHALL compute only interior pixels: output frame is (IMG_W-2) x (IMG_H-2), centre (r,c) for r in 1..IMG_H-2, c in 1..IMG_W-2.
REQ-017 SHALL buffer two previous lines plus a 3x3 window register array fed from the accepted input stream.
REQ-018 SHALL implement states IDLE (await s_sof), FILL (rows 0-1 and first two columns of each line), RUN (window complete); IDLE->FILL on accepted s_sof pixel; FILL->RUN when pixel (r>=2, c>=2) accepted; RUN->FILL at start of each new line; ->IDLE after pixel (IMG_H-1, IMG_W-1) accepted.
REQ-019 SHALL, in IDLE, accept and discard pixels without s_sof (s_ready=1).
REQ-020 SHALL, on an accepted s_sof pixel in any state, restart row/column counters at (0,0) and drop the partial frame; pipeline outputs already computed still drain.
REQ-021 SHALL compute box mode as m_data = (S*7282 + 32768) >> 16, S = unsigned sum of 9 pixels, full-precision intermediate (PIX_W+4 bit sum, PIX_W+18 bit product).
REQ-022 SHALL compute Gaussian mode as m_data = (W + 8) >> 4, W = corner*1 + edge*2 + centre*4, PIX_W+4 bit intermediate.
REQ-023 SHALL never overflow m_data: all-max input yields all-max output.
REQ-024 SHALL use a 2-stage pipeline (sum, scale): output for centre (r,c) presented with m_valid 2 cycles after input (r+1,c+1) accepted, absent back-pressure.
REQ-025 SHALL apply global stall: s_ready = !(m_valid && !m_ready); while stalled no pipeline, counter, or line-buffer state changes.
REQ-026 SHALL hold m_data, m_sof, m_eol stable while m_valid && !m_ready.
REQ-027 SHALL sample mode with each window entering the sum stage; mode changes mid-frame take effect per pixel.
REQ-028 SHALL assert m_sof with output (1,1) and m_eol with output (r, IMG_W-2).

Reset
REQ-029 SHALL, while reset low, force state IDLE, counters 0, m_valid 0, m_data 0, m_sof 0, m_eol 0, s_ready 1.
REQ-030 SHALL, on reset assertion mid-frame, discard all buffered and in-flight data; line-buffer contents need not be cleared.

Configuration
REQ-031 SHALL support macro SMOOTH_GAUSS_EN: defined -> mode selects per REQ-010/022; undefined -> Gaussian datapath absent, mode ignored, box average always.

Structure
REQ-032 SHALL place state enum, reciprocal constant 7282, rounding constants, and Gaussian weights in package smooth_pkg.
REQ-033 SHALL implement line storage in sub-module smooth_line_buf (IMG_W-deep, PIX_W-wide, one write and one read per accepted pixel, stall-aware enable).

Verification
REQ-034 SHALL cover: IMG_W=IMG_H=5, all pixels 255, mode 0, m_ready=1 -> 9 outputs of 255, m_sof on first, m_eol on 3rd/6th/9th.
REQ-035 SHALL cover: frame of all 255 followed by frame of all 20 -> first frame outputs 255, second frame outputs 20, no cross-frame mixing.
REQ-036 SHALL cover: mode 1, single centre pixel 4095 in zero 5x5 frame -> output at that centre (4095*4+8)>>4 = 1024, four edge neighbours 512, four corner neighbours 256.
REQ-037 SHALL cover: m_ready toggled 0/1 every 3 cycles -> s_ready low exactly while m_valid && !m_ready; output sequence identical to unstalled run.
REQ-038 SHALL cover: reset pulsed low mid-frame, then new s_sof frame of all 20 -> m_valid 0 during reset, subsequent outputs all 20.
REQ-039 SHALL cover: s_sof reasserted at row 2 col 3 -> counters restart, next outputs correspond to new frame only.

Source files
------------

// File: rtl/smooth_pkg.sv
// Shared types and constants for the smooth_stream 3x3 smoothing filter.
package smooth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_RUN
    } state_t;

    // Sum stage then scale stage after the window register.
    localparam int PIPE_STAGES = 2;

    // Box average: S/9 approximated as (S*7282 + 2^15) >> 16.
    localparam int BOX_RECIP = 7282;
    localparam int BOX_RND   = 32768;
    localparam int BOX_SHIFT = 16;

    // Gaussian 1-2-1 kernel; weights sum to 16.
    localparam int G_W_CORNER = 1;
    localparam int G_W_EDGE   = 2;
    localparam int G_W_CENTRE = 4;
    localparam int G_RND      = 8;
    localparam int G_SHIFT    = 4;

endpackage

// File: rtl/smooth_line_buf.sv
// One line of pixel storage: read-before-write at the same column, gated by accept.
module smooth_line_buf #(
    parameter int PIX_W = 12,
    parameter int DEPTH = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_en,
    input  logic [AW-1:0]    i_addr,
    input  logic [PIX_W-1:0] i_wdata,
    output logic [PIX_W-1:0] o_rdata
);

    logic [PIX_W-1:0] r_mem [DEPTH];

    assign o_rdata = r_mem[i_addr];

    always_ff @(posedge clk) begin
        if (i_en) r_mem[i_addr] <= i_wdata;
    end

endmodule

// File: rtl/smooth_stream.sv
// smooth_stream: streaming 3x3 box / Gaussian smoother emitting interior pixels only.
// Define SMOOTH_GAUSS_EN to build the Gaussian datapath selected per pixel by `mode`.
module smooth_stream
    import smooth_pkg::*;
#(
    parameter int PIX_W = 12,
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             s_sof,
    input  logic [PIX_W-1:0] s_data,
    input  logic             mode,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [PIX_W-1:0] m_data,
    output logic             m_sof,
    output logic             m_eol
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int SW = PIX_W + 4;
    localparam int PW = PIX_W + 18;
    localparam logic [CW-1:0]    COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0]    ROW_LAST = RW'(IMG_H - 1);
    localparam logic [PIX_W-1:0] PIX_MAX  = '1;

    state_t                   r_state, w_state_nxt;
    logic [RW-1:0]            r_row, w_row_nxt, w_row;
    logic [CW-1:0]            r_col, w_col_nxt, w_col;
    logic                     w_stall, w_acc, w_live, w_win_vld, w_sof_pix, w_eol_pix;
    logic [PIX_W-1:0]         w_lb0_q, w_lb1_q;
    logic [2:0][2:0][PIX_W-1:0] r_win;
    logic [PIPE_STAGES:0]     r_vld_pipe, r_sof_pipe, r_eol_pipe;
    logic [SW-1:0]            r_sum, w_box_sum;
    logic [PW-1:0]            w_box_q;
    logic [PIX_W-1:0]         r_m_data, w_out;

    assign w_stall = r_vld_pipe[PIPE_STAGES] && !m_ready;
    assign s_ready = !w_stall;
    assign w_acc   = s_valid && s_ready;

    // An accepted s_sof pixel is always (0,0), whatever the counters say.
    assign w_row     = s_sof ? '0 : r_row;
    assign w_col     = s_sof ? '0 : r_col;
    assign w_live    = w_acc && (s_sof || r_state != ST_IDLE);
    assign w_win_vld = w_live && w_row >= RW'(2) && w_col >= CW'(2);
    assign w_sof_pix = w_row == RW'(2) && w_col == CW'(2);
    assign w_eol_pix = w_col == COL_LAST;

    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        if (w_live) begin
            if (w_col == COL_LAST) begin
                w_col_nxt = '0;
                if (w_row == ROW_LAST) begin
                    w_row_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_row_nxt   = w_row + RW'(1);
                    w_state_nxt = ST_FILL;
                end
            end else begin
                w_col_nxt   = w_col + CW'(1);
                w_row_nxt   = w_row;
                w_state_nxt = (w_row >= RW'(2) && w_col >= CW'(2)) ? ST_RUN : ST_FILL;
            end
        end
    end

    // lb0 holds the previous line, lb1 the one before; lb1 is fed from lb0's old value.
    smooth_line_buf #(.PIX_W(PIX_W), .DEPTH(IMG_W)) u_lb0 (
        .clk    (clk),
        .i_en   (w_live),
        .i_addr (w_col),
        .i_wdata(s_data),
        .o_rdata(w_lb0_q)
    );

    smooth_line_buf #(.PIX_W(PIX_W), .DEPTH(IMG_W)) u_lb1 (
        .clk    (clk),
        .i_en   (w_live),
        .i_addr (w_col),
        .i_wdata(w_lb0_q),
        .o_rdata(w_lb1_q)
    );

    // Window row 0 is oldest line, column 2 is newest pixel.
    always_ff @(posedge clk) begin
        if (w_live) begin
            for (int i = 0; i < 3; i++) begin
                r_win[i][0] <= r_win[i][1];
                r_win[i][1] <= r_win[i][2];
            end
            r_win[0][2] <= w_lb1_q;
            r_win[1][2] <= w_lb0_q;
            r_win[2][2] <= s_data;
        end
    end

    always_comb begin
        w_box_sum = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w_box_sum = w_box_sum + SW'(r_win[i][j]);
    end

    assign w_box_q = (PW'(r_sum) * PW'(BOX_RECIP) + PW'(BOX_RND)) >> BOX_SHIFT;

`ifdef SMOOTH_GAUSS_EN
    logic [SW-1:0] w_g_sum, w_g_q;
    logic          r_gmode;

    assign w_g_sum = SW'(G_W_CORNER) * (SW'(r_win[0][0]) + SW'(r_win[0][2])
                                      + SW'(r_win[2][0]) + SW'(r_win[2][2]))
                   + SW'(G_W_EDGE)   * (SW'(r_win[0][1]) + SW'(r_win[1][0])
                                      + SW'(r_win[1][2]) + SW'(r_win[2][1]))
                   + SW'(G_W_CENTRE) * SW'(r_win[1][1]);
    assign w_g_q   = (r_sum + SW'(G_RND)) >> G_SHIFT;

    always_ff @(posedge clk) begin
        if (!w_stall && r_vld_pipe[0]) begin
            r_sum   <= mode ? w_g_sum : w_box_sum;
            r_gmode <= mode;
        end
    end

    always_comb begin
        w_out = (w_box_q > PW'(PIX_MAX)) ? PIX_MAX : w_box_q[PIX_W-1:0];
        if (r_gmode) w_out = (w_g_q > SW'(PIX_MAX)) ? PIX_MAX : w_g_q[PIX_W-1:0];
    end
`else
    logic w_unused_mode;
    assign w_unused_mode = mode;

    always_ff @(posedge clk) begin
        if (!w_stall && r_vld_pipe[0]) r_sum <= w_box_sum;
    end

    always_comb begin
        w_out = (w_box_q > PW'(PIX_MAX)) ? PIX_MAX : w_box_q[PIX_W-1:0];
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_row      <= '0;
            r_col      <= '0;
            r_vld_pipe <= '0;
            r_sof_pipe <= '0;
            r_eol_pipe <= '0;
            r_m_data   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
            r_col   <= w_col_nxt;
            if (!w_stall) begin
                r_vld_pipe <= {r_vld_pipe[PIPE_STAGES-1:0], w_win_vld};
                r_sof_pipe <= {r_sof_pipe[PIPE_STAGES-1:0], w_win_vld && w_sof_pix};
                r_eol_pipe <= {r_eol_pipe[PIPE_STAGES-1:0], w_win_vld && w_eol_pix};
                if (r_vld_pipe[PIPE_STAGES-1]) r_m_data <= w_out;
            end
        end
    end

    assign m_valid = r_vld_pipe[PIPE_STAGES];
    assign m_sof   = r_sof_pipe[PIPE_STAGES];
    assign m_eol   = r_eol_pipe[PIPE_STAGES];
    assign m_data  = r_m_data;

endmodule

// File: tb/tb_smooth_stream.sv
// Directed bench for smooth_stream on a 5x5 frame; impulse expectations follow SMOOTH_GAUSS_EN.
module tb_smooth_stream;

    localparam int PIX_W = 12;
    localparam int IMG_W = 5;
    localparam int IMG_H = 5;
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int OW    = IMG_W - 2;
    localparam int NOUT  = OW * (IMG_H - 2);
    localparam int CTR   = 2 * IMG_W + 2;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             s_valid = 1'b0, s_sof = 1'b0, mode = 1'b0, m_ready = 1'b1;
    logic             s_ready, m_valid, m_sof, m_eol;
    logic [PIX_W-1:0] s_data = '0, m_data;

    smooth_stream #(.PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_ready(s_ready), .s_sof(s_sof), .s_data(s_data),
        .mode(mode),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_sof(m_sof), .m_eol(m_eol)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Output monitor plus handshake-rule and hold-under-stall watchers.
    logic [PIX_W-1:0] q_data[$];
    logic [1:0]       q_flag[$];
    int               q_cyc[$];
    int               n_rule_err = 0;
    int               n_hold_err = 0;
    logic             prev_stall = 1'b0;
    logic [PIX_W+2:0] prev_out = '0;

    always @(negedge clk) begin
        if (s_ready !== !(m_valid && !m_ready)) n_rule_err <= n_rule_err + 1;
        if (reset && prev_stall && prev_out !== {m_valid, m_sof, m_eol, m_data})
            n_hold_err <= n_hold_err + 1;
        prev_stall <= reset && m_valid && !m_ready;
        prev_out   <= {m_valid, m_sof, m_eol, m_data};
        if (m_valid && m_ready) begin
            q_data.push_back(m_data);
            q_flag.push_back({m_sof, m_eol});
            q_cyc.push_back(cyc);
        end
    end

    logic [PIX_W-1:0] frm [NPIX];
    int               exp_d [NOUT];
    int               lat_cyc = 0;

    task automatic fill_const(input int v);
        for (int i = 0; i < NPIX; i++) frm[i] = PIX_W'(v);
    endtask

    // Linear ramp: any symmetric normalised 3x3 kernel returns the centre value.
    task automatic fill_ramp();
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++) frm[r*IMG_W + c] = PIX_W'(10*r + c);
        for (int k = 0; k < NOUT; k++) exp_d[k] = 10*(k/OW + 1) + (k%OW + 1);
    endtask

    task automatic exp_const(input int v);
        for (int k = 0; k < NOUT; k++) exp_d[k] = v;
    endtask

    task automatic send_pix(input logic [PIX_W-1:0] d, input logic sof, output int acc);
        int n = 0;
        s_valid = 1'b1; s_data = d; s_sof = sof;
        @(negedge clk);
        while (!s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) chk("send_timeout", 32'(s_ready), 32'd1);
        @(posedge clk); #1;
        acc = cyc;
        s_valid = 1'b0; s_sof = 1'b0;
    endtask

    task automatic send_frame(input int first, input int last, input logic sof_first);
        int acc;
        for (int i = first; i <= last; i++) begin
            send_pix(frm[i], sof_first && (i == first), acc);
            if (i == CTR) lat_cyc = acc;
        end
    endtask

    task automatic wait_outs(input int total);
        int n = 0;
        while (q_data.size() < total && n < 400) begin
            @(posedge clk);
            n++;
        end
        repeat (6) @(posedge clk);
        #1;
        chk("out_count", q_data.size(), total);
    endtask

    task automatic check_outs(input string tag, input int base);
        for (int k = 0; k < NOUT; k++) begin
            if (base + k < q_data.size()) begin
                chk($sformatf("%s_data%0d", tag, k), q_data[base+k], exp_d[k]);
                chk($sformatf("%s_flag%0d", tag, k), q_flag[base+k],
                    {30'd0, k == 0, (k % OW) == OW - 1});
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, lat0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state", {m_valid, m_sof, m_eol, s_ready, m_data}, {4'b0001, 12'd0});
        reset = 1'b1;
        @(posedge clk); #1;

        // All-255 frame, discarded junk in IDLE, then all-20 frame back to back.
        mode = 1'b0;
        fill_const(255);
        send_frame(0, NPIX-1, 1'b1);
        lat0 = lat_cyc;
        for (int i = 0; i < 3; i++) send_pix(PIX_W'(4095), 1'b0, base);
        fill_const(20);
        send_frame(0, NPIX-1, 1'b1);
        wait_outs(2*NOUT);
        exp_const(255);
        check_outs("max", 0);
        if (q_cyc.size() > 0) chk("latency", q_cyc[0] - lat0, 2);
        exp_const(20);
        check_outs("next_frame", NOUT);

        // Single 4095 impulse at centre (2,2) with mode = 1.
        base = q_data.size();
        mode = 1'b1;
        fill_const(0);
        frm[CTR] = PIX_W'(4095);
`ifdef SMOOTH_GAUSS_EN
        exp_d = '{256, 512, 256, 512, 1024, 512, 256, 512, 256};
`else
        exp_const(455);
`endif
        send_frame(0, NPIX-1, 1'b1);
        wait_outs(base + NOUT);
        check_outs("impulse", base);
        mode = 1'b0;

        // Ramp frame under m_ready toggling every 3 cycles.
        base = q_data.size();
        fill_ramp();
        fork
            send_frame(0, NPIX-1, 1'b1);
            begin
                for (int k = 0; k < 30; k++) begin
                    m_ready = (k % 2) == 1;
                    repeat (3) @(posedge clk);
                    #1;
                end
                m_ready = 1'b1;
            end
        join
        wait_outs(base + NOUT);
        check_outs("stall", base);

        // Reset mid-frame just after the first full window is accepted.
        base = q_data.size();
        fill_const(255);
        send_frame(0, CTR, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_a", {m_valid, s_ready}, 2'b01);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("midrst_b", {m_valid, m_sof, m_eol}, 3'b000);
        reset = 1'b1;
        @(posedge clk); #1;
        fill_const(20);
        send_frame(0, NPIX-1, 1'b1);
        wait_outs(base + NOUT);
        exp_const(20);
        check_outs("after_rst", base);

        // s_sof re-asserted at (2,3): one drained output from the old frame, then the new one.
        base = q_data.size();
        fill_const(255);
        send_frame(0, CTR, 1'b1);
        fill_ramp();
        send_frame(0, NPIX-1, 1'b1);
        wait_outs(base + 1 + NOUT);
        if (q_data.size() > base) begin
            chk("restart_old_data", q_data[base], 255);
            chk("restart_old_flag", q_flag[base], 2'b10);
        end
        check_outs("restart", base + 1);

        chk("sready_rule", n_rule_err, 0);
        chk("hold_stable", n_hold_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
